// File: rtl/grf_param.sv
// Parameterized general-purpose register file: two combinational read ports with write bypass,
// one write port, and a sequential clear that zeroes one entry per clock.
`timescale 1ns/1ps
module grf_param #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              clr_req,
    output logic              clr_busy
);

    localparam int unsigned DEPTH = 32'(1) << ADDR_W;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_next;
    logic              clr_zero_c;
    logic              wr_valid_c;
    logic              zero_hit1_c;
    logic              zero_hit2_c;

    logic [DATA_W-1:0] mem [DEPTH];

    // State and clear-pointer registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    // Next-state: a clear walks ptr from 0 to DEPTH-1, one entry per edge
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        clr_zero_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (clr_req) begin
                    state_next = S_CLEAR;
                    ptr_next   = '0;
                end
            end
            S_CLEAR: begin
                clr_zero_c = 1'b1;
                ptr_next   = ptr + ADDR_W'(1);
                if (ptr == ADDR_W'(DEPTH - 1)) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
                ptr_next   = '0;
            end
        endcase
    end

    assign clr_busy = (state == S_CLEAR);

    // Writes only land in IDLE, outside reset, and never on a hardwired-zero entry 0
    assign wr_valid_c = we && !reset && (state == S_IDLE)
                        && !((ZERO_REG != 0) && (waddr == '0));

    // Storage: async clear of every entry, otherwise clear-walk or write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr_zero_c) begin
            mem[ptr] <= '0;
        end else if (wr_valid_c) begin
            mem[waddr] <= wdata;
        end
    end

    assign zero_hit1_c = (ZERO_REG != 0) && (raddr1 == '0);
    assign zero_hit2_c = (ZERO_REG != 0) && (raddr2 == '0);

    // Read ports: forced zero, then same-cycle bypass of a valid write, then stored data
    assign rdata1 = (reset || zero_hit1_c)             ? '0    :
                    (wr_valid_c && (waddr == raddr1))  ? wdata : mem[raddr1];
    assign rdata2 = (reset || zero_hit2_c)             ? '0    :
                    (wr_valid_c && (waddr == raddr2))  ? wdata : mem[raddr2];

endmodule

// File: tb/tb_grf_param.sv
// Directed bench for grf_param: default 32x32 instance with zero register, plus an 8x8 instance without.
`timescale 1ns/1ps
module tb_grf_param;

    logic        clk;
    logic        reset;

    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        clr_req;
    logic        clr_busy;

    logic        b_we;
    logic [2:0]  b_waddr;
    logic [7:0]  b_wdata;
    logic [2:0]  b_raddr1;
    logic [2:0]  b_raddr2;
    logic [7:0]  b_rdata1;
    logic [7:0]  b_rdata2;
    logic        b_clr_req;
    logic        b_clr_busy;

    int checks = 0;
    int errors = 0;

    grf_param dut_a (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
        .clr_req(clr_req), .clr_busy(clr_busy)
    );

    grf_param #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(0)) dut_b (
        .clk(clk), .reset(reset), .we(b_we), .waddr(b_waddr), .wdata(b_wdata),
        .raddr1(b_raddr1), .raddr2(b_raddr2), .rdata1(b_rdata1), .rdata2(b_rdata2),
        .clr_req(b_clr_req), .clr_busy(b_clr_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we    = 1'b1;
        waddr = a;
        wdata = d;
        @(posedge clk); #1;
        we    = 1'b0;
    endtask

    initial begin
        int busy_cnt;
        int guard;

        reset = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr1 = 5'd5; raddr2 = 5'd6; clr_req = 1'b0;
        b_we = 1'b0; b_waddr = '0; b_wdata = '0; b_raddr1 = '0; b_raddr2 = '0; b_clr_req = 1'b0;
        #1 reset = 1'b1;
        #2;
        chk("rst_rd1", rdata1, 32'h0);
        chk("rst_busy", 32'(clr_busy), 32'h0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // Basic write and read-back
        wr(5'd5, 32'hDEADBEEF);
        raddr1 = 5'd5; raddr2 = 5'd6; #1;
        chk("wr5_rd1", rdata1, 32'hDEADBEEF);
        chk("rd6_zero", rdata2, 32'h0);

        // Hardwired zero entry
        we = 1'b1; waddr = 5'd0; wdata = 32'h12345678; raddr1 = 5'd0; #1;
        chk("zero_same", rdata1, 32'h0);
        @(posedge clk); #1;
        we = 1'b0; #1;
        chk("zero_after", rdata1, 32'h0);

        // Same-cycle bypass, both ports on one address
        we = 1'b1; waddr = 5'd9; wdata = 32'hA5A5A5A5; raddr1 = 5'd9; raddr2 = 5'd9; #1;
        chk("byp_rd2", rdata2, 32'hA5A5A5A5);
        chk("byp_rd1", rdata1, 32'hA5A5A5A5);
        @(posedge clk); #1;
        we = 1'b0; #1;
        chk("byp_stored", rdata2, 32'hA5A5A5A5);

        // Fill with index values, then clear
        for (int i = 0; i < 32; i++) wr(5'(i), 32'(i));
        raddr1 = 5'd20; raddr2 = 5'd31; #1;
        chk("fill_e20", rdata1, 32'd20);
        chk("fill_e31", rdata2, 32'd31);
        clr_req = 1'b1;
        @(posedge clk); #1;
        clr_req = 1'b0;
        busy_cnt = 0; guard = 0;
        while (clr_busy && guard < 100) begin
            busy_cnt++;
            if (busy_cnt == 21) chk("clr_e20_pre", rdata1, 32'd20);
            if (busy_cnt == 22) chk("clr_e20_post", rdata1, 32'd0);
            if (busy_cnt == 5) begin
                we = 1'b1; waddr = 5'd2; wdata = 32'h0000FFFF; raddr2 = 5'd2; #1;
                chk("clr_no_bypass", rdata2, 32'h0);
            end
            if (busy_cnt == 10) clr_req = 1'b1;
            @(posedge clk); #1;
            we = 1'b0; clr_req = 1'b0;
            guard++;
        end
        chk("clr_len32", 32'(busy_cnt), 32'd32);
        raddr1 = 5'd2; raddr2 = 5'd31; #1;
        chk("clr_wr_dropped", rdata1, 32'h0);
        chk("clr_e31", rdata2, 32'h0);
        @(posedge clk); #1;
        chk("clr_no_restart", 32'(clr_busy), 32'h0);

        // Write coinciding with clear request lands, then gets cleared
        we = 1'b1; waddr = 5'd7; wdata = 32'h00000077; clr_req = 1'b1;
        @(posedge clk); #1;
        we = 1'b0; clr_req = 1'b0; raddr1 = 5'd7; #1;
        chk("wrclr_written", rdata1, 32'h77);
        chk("wrclr_busy", 32'(clr_busy), 32'h1);
        guard = 0;
        while (clr_busy && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("wrclr_done", 32'(clr_busy), 32'h0);
        chk("wrclr_zeroed", rdata1, 32'h0);

        // Asynchronous reset in the middle of a clear
        wr(5'd12, 32'h00C0FFEE);
        wr(5'd15, 32'h00001515);
        clr_req = 1'b1;
        @(posedge clk); #1;
        clr_req = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        raddr1 = 5'd15; raddr2 = 5'd12; #1;
        chk("mid_e15", rdata1, 32'h00001515);
        chk("mid_busy", 32'(clr_busy), 32'h1);
        #1 reset = 1'b1;
        #1;
        chk("arst_busy", 32'(clr_busy), 32'h0);
        chk("arst_e15", rdata1, 32'h0);
        chk("arst_e12", rdata2, 32'h0);
        we = 1'b1; waddr = 5'd15; wdata = 32'h00000099; clr_req = 1'b1;
        #2;
        chk("inrst_rd", rdata1, 32'h0);
        we = 1'b0; clr_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; #1;
        chk("post_e15", rdata1, 32'h0);
        @(posedge clk); #1;
        chk("post_idle", 32'(clr_busy), 32'h0);
        wr(5'd15, 32'h0000ABCD);
        chk("post_wr", rdata1, 32'h0000ABCD);

        // Narrow instance with ordinary entry 0
        b_we = 1'b1; b_waddr = 3'd0; b_wdata = 8'h7F;
        @(posedge clk); #1;
        b_we = 1'b0; b_raddr1 = 3'd0; b_raddr2 = 3'd0; #1;
        chk("b_e0_rd1", 32'(b_rdata1), 32'h7F);
        chk("b_e0_rd2", 32'(b_rdata2), 32'h7F);
        b_clr_req = 1'b1;
        @(posedge clk); #1;
        b_clr_req = 1'b0;
        busy_cnt = 0; guard = 0;
        while (b_clr_busy && guard < 100) begin
            busy_cnt++;
            @(posedge clk); #1;
            guard++;
        end
        chk("b_clr_len8", 32'(busy_cnt), 32'd8);
        chk("b_e0_cleared", 32'(b_rdata1), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/grf_param.md
GRF_PARAM -- requirements
Module: grf_param

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the bit width of every register entry.
REQ-002 Parameter ADDR_W, default 5, SHALL set the address width; DEPTH SHALL equal 2**ADDR_W entries.
REQ-003 Parameter ZERO_REG, default 1, SHALL make entry 0 read-only zero when 1; when 0, entry 0 SHALL be an ordinary entry.
REQ-004 Port clk, input, 1, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 Port reset, input, 1, SHALL be the asynchronous, active-high reset.
REQ-006 Port we, input, 1, SHALL be the write enable.
REQ-007 Port waddr, input, ADDR_W, SHALL be the write address.
REQ-008 Port wdata, input, DATA_W, SHALL be the write data.
REQ-009 Ports raddr1 and raddr2, input, ADDR_W each, SHALL be the read addresses.
REQ-010 Ports rdata1 and rdata2, output, DATA_W each, SHALL be the read data.
REQ-011 Port clr_req, input, 1, SHALL be a single-cycle request to start a sequential clear.
REQ-012 Port clr_busy, output, 1, SHALL be high while a sequential clear is in progress.

Function
REQ-013 A write SHALL be valid when we=1, the FSM is in IDLE, and not (ZERO_REG=1 and waddr=0).
REQ-014 A valid write SHALL store wdata at entry waddr on the rising edge of clk.
REQ-015 Reads SHALL be combinational; rdataN SHALL equal the stored contents of entry raddrN.
REQ-016 With ZERO_REG=1, raddrN=0 SHALL return 0 regardless of any other condition.
REQ-017 Bypass: if a valid write is present and waddr=raddrN, rdataN SHALL equal wdata in the same cycle.
REQ-018 Both read ports SHALL be independent; identical addresses SHALL return identical data.
REQ-019 The FSM SHALL have exactly two states, IDLE and CLEAR, and a pointer ptr of ADDR_W bits.
REQ-020 In IDLE, clr_req=1 SHALL move the FSM to CLEAR at the next edge with ptr=0.
REQ-021 In CLEAR, each edge SHALL zero entry ptr and increment ptr.
REQ-022 In CLEAR, the edge that zeroes entry DEPTH-1 SHALL return the FSM to IDLE with ptr wrapping to 0.
REQ-023 clr_busy SHALL be 1 exactly while in CLEAR, for DEPTH consecutive cycles per clear.
REQ-024 In CLEAR, we SHALL be ignored: no write and no bypass.
REQ-025 In CLEAR, reads SHALL return current stored contents; entries not yet cleared keep their old values.
REQ-026 In CLEAR, clr_req SHALL be ignored and SHALL NOT restart or extend the clear.
REQ-027 In IDLE, if clr_req=1 and a valid write occur together, the write SHALL be performed at that edge; the subsequent clear SHALL later zero that entry.

Reset
REQ-028 reset=1 SHALL immediately, without a clock edge, set all entries to 0, the FSM to IDLE, ptr to 0, and clr_busy to 0.
REQ-029 reset asserted during CLEAR SHALL abort the clear; after release the FSM SHALL be in IDLE.
REQ-030 While reset=1, writes and clr_req SHALL have no effect; rdata1 and rdata2 SHALL read 0.

Verification
REQ-031 Reset, then write 0xDEADBEEF to entry 5 -> raddr1=5 reads 0xDEADBEEF on the next cycle; raddr2=6 reads 0.
REQ-032 ZERO_REG=1: write 0x12345678 to entry 0 -> raddr1=0 reads 0 both in the same cycle and afterwards.
REQ-033 we=1, waddr=raddr2=9, wdata=0xA5A5A5A5 in IDLE -> rdata2=0xA5A5A5A5 combinationally, before the edge.
REQ-034 Fill all 32 entries with the value of their index, then pulse clr_req -> clr_busy high for exactly 32 cycles; entry 20 reads 20 until the 21st busy cycle, then 0; a write attempted during busy is dropped.
REQ-035 Assert reset asynchronously mid-clear (ptr=10) -> clr_busy=0 and all entries read 0 with no clock edge; a write after release succeeds.
REQ-036 Run with DATA_W=8, ADDR_W=3, ZERO_REG=0 -> entry 0 is writable (0x7F reads back) and a clear lasts exactly 8 cycles.
